// File: rtl/avr_hvpp_pkg.sv
// rtl/avr_hvpp_pkg.sv - shared types and pin codes for the HVPP sequencer
// Contents: op codes, FSM state encoding, XA1/XA0 pin codes, reserved-op helper.
package avr_hvpp_pkg;

    typedef enum logic [2:0] {
        OP_LOAD_CMD  = 3'd0,
        OP_LOAD_ADDR = 3'd1,
        OP_LOAD_DATA = 3'd2,
        OP_WRITE     = 3'd3,
        OP_READ      = 3'd4,
        OP_PAGEL     = 3'd5,
        OP_RSVD6     = 3'd6,
        OP_RSVD7     = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT_BSY,
        ST_WAIT_RDY,
        ST_HOLD,
        ST_DONE
    } state_e;

    // {XA1, XA0}
    localparam logic [1:0] XA_ADDR = 2'b00;
    localparam logic [1:0] XA_DATA = 2'b01;
    localparam logic [1:0] XA_CMD  = 2'b10;
    localparam logic [1:0] XA_IDLE = 2'b11;

    function automatic logic op_is_reserved(input op_e op);
        return (op == OP_RSVD6) || (op == OP_RSVD7);
    endfunction

endpackage

// File: rtl/hvpp_cycle_timer.sv
// rtl/hvpp_cycle_timer.sv - loadable down-counter with done flag
// Ports: clk, rst_n (async, active low); i_load/i_count load a state length of
// i_count cycles; o_done is high in the last cycle of that length.
module hvpp_cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_count,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Loading N leaves N-1 in the counter so the state that follows the load
    // lasts exactly N cycles, with done asserted in the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= (i_count == '0) ? '0 : i_count - W'(1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/avr_hvpp_sequencer.sv
// rtl/avr_hvpp_sequencer.sv - timed pin sequencer for AVR high-voltage parallel programming
// Ports: cmd_* (one byte-level op at a time), rsp_* (completion pulse, read byte,
// RDY timeout error), dut_* (ZIF pin drives, data bus and asynchronous RDY/BSY).
// Build option HVPP_RDY_TIMEOUT_EN: bounds WAIT_RDY to TIMEOUT_CYC cycles and
// reports the expiry on rsp_err; without it WAIT_RDY waits until RDY or reset.
module avr_hvpp_sequencer
    import avr_hvpp_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 4,
    parameter int READ_CYC    = 3,
    parameter int BSY_CYC     = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic       cmd_bs1,
    input  logic       cmd_bs2,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       dut_xa0,
    output logic       dut_xa1_bs2,
    output logic       dut_pagel_bs1,
    output logic       dut_xtal,
    output logic       dut_wr_n,
    output logic       dut_oe_n,
    output logic [7:0] dut_data_out,
    output logic       dut_data_oe,
    input  logic [7:0] dut_data_in,
    input  logic       dut_rdy
);

    localparam logic [15:0] L_SETUP   = 16'(SETUP_CYC);
    localparam logic [15:0] L_PULSE   = 16'(PULSE_CYC);
    localparam logic [15:0] L_READ    = 16'(READ_CYC);
    localparam logic [15:0] L_BSY     = 16'(BSY_CYC);
    localparam logic [15:0] L_TIMEOUT = 16'(TIMEOUT_CYC);

    state_e      r_state, w_state_nxt;
    op_e         r_op;
    logic        r_bs1, r_bs2;
    logic [7:0]  r_data, r_rsp_data;
    logic        r_rdy_meta, r_rdy_s;
    logic        w_accept, w_load, w_timer_done, w_active;
    logic [15:0] w_load_val;

    // RDY/BSY comes straight from the target; idle level is high (ready).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_meta <= 1'b1;
            r_rdy_s    <= 1'b1;
        end else begin
            r_rdy_meta <= dut_rdy;
            r_rdy_s    <= r_rdy_meta;
        end
    end

    hvpp_cycle_timer #(.W(16)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_count (w_load_val),
        .o_done  (w_timer_done)
    );

`ifdef HVPP_RDY_TIMEOUT_EN
    logic w_timeout;
    logic r_err;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_load_val  = L_SETUP;
`ifdef HVPP_RDY_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    if (op_is_reserved(op_e'(cmd_op))) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SETUP;
                        w_load      = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (w_timer_done) begin
                    w_state_nxt = ST_STROBE;
                    w_load      = 1'b1;
                    w_load_val  = (r_op == OP_READ) ? L_READ : L_PULSE;
                end
            end
            ST_STROBE: begin
                if (w_timer_done) begin
                    w_load = 1'b1;
                    if (r_op == OP_WRITE) begin
                        w_state_nxt = ST_WAIT_BSY;
                        w_load_val  = L_BSY;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_WAIT_BSY: begin
                // A fast write may finish before BSY is ever seen; the window
                // bound lets the op complete instead of waiting forever.
                if (!r_rdy_s) begin
                    w_state_nxt = ST_WAIT_RDY;
                    w_load      = 1'b1;
                    w_load_val  = L_TIMEOUT;
                end else if (w_timer_done) begin
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                end
            end
            ST_WAIT_RDY: begin
                if (r_rdy_s) begin
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                end
`ifdef HVPP_RDY_TIMEOUT_EN
                else if (w_timer_done) begin
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                    w_timeout   = 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (w_timer_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_LOAD_CMD;
            r_bs1      <= 1'b0;
            r_bs2      <= 1'b0;
            r_data     <= 8'h00;
            r_rsp_data <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op   <= op_e'(cmd_op);
                r_bs1  <= cmd_bs1;
                r_bs2  <= cmd_bs2;
                r_data <= cmd_data;
            end
            // Sample on the last OE-low cycle so the target has had READ_CYC
            // cycles of output enable before the bus is captured.
            if (r_state == ST_STROBE && r_op == OP_READ && w_timer_done) begin
                r_rsp_data <= dut_data_in;
            end
        end
    end

`ifdef HVPP_RDY_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end
    assign rsp_err = r_err && (r_state == ST_DONE);
`else
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready    = (r_state == ST_IDLE);
    assign rsp_valid    = (r_state == ST_DONE);
    assign rsp_data     = r_rsp_data;
    assign dut_data_out = r_data;
    assign w_active     = (r_state != ST_IDLE) && (r_state != ST_DONE);

    // Pins are decoded from registered state and op only; control/data levels
    // persist through SETUP..HOLD so setup and hold bracket the strobe.
    always_comb begin
        {dut_xa1_bs2, dut_xa0} = XA_IDLE;
        dut_pagel_bs1 = 1'b0;
        dut_xtal      = 1'b0;
        dut_wr_n      = 1'b1;
        dut_oe_n      = 1'b1;
        dut_data_oe   = 1'b0;
        if (w_active) begin
            case (r_op)
                OP_LOAD_CMD: begin
                    {dut_xa1_bs2, dut_xa0} = XA_CMD;
                    dut_data_oe = 1'b1;
                end
                OP_LOAD_ADDR: begin
                    {dut_xa1_bs2, dut_xa0} = XA_ADDR;
                    dut_pagel_bs1 = r_bs1;
                    dut_data_oe   = 1'b1;
                end
                OP_LOAD_DATA: begin
                    {dut_xa1_bs2, dut_xa0} = XA_DATA;
                    dut_pagel_bs1 = r_bs1;
                    dut_data_oe   = 1'b1;
                end
                OP_WRITE, OP_READ: begin
                    dut_xa1_bs2   = r_bs2;
                    dut_pagel_bs1 = r_bs1;
                end
                default: ;
            endcase
        end
        if (r_state == ST_STROBE) begin
            case (r_op)
                OP_LOAD_CMD, OP_LOAD_ADDR, OP_LOAD_DATA: dut_xtal = 1'b1;
                OP_PAGEL: dut_pagel_bs1 = 1'b1;
                OP_WRITE: dut_wr_n      = 1'b0;
                OP_READ:  dut_oe_n      = 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_avr_hvpp_sequencer.sv
// tb/tb_avr_hvpp_sequencer.sv - self-checking bench for avr_hvpp_sequencer
module tb_avr_hvpp_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic       cmd_bs1 = 1'b0;
    logic       cmd_bs2 = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       dut_xa0, dut_xa1_bs2, dut_pagel_bs1, dut_xtal, dut_wr_n, dut_oe_n;
    logic [7:0] dut_data_out;
    logic       dut_data_oe;
    logic [7:0] dut_data_in = 8'h00;
    logic       dut_rdy = 1'b1;

    always #5 clk = ~clk;

    avr_hvpp_sequencer #(.TIMEOUT_CYC(100)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_bs1       (cmd_bs1),
        .cmd_bs2       (cmd_bs2),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .dut_xa0       (dut_xa0),
        .dut_xa1_bs2   (dut_xa1_bs2),
        .dut_pagel_bs1 (dut_pagel_bs1),
        .dut_xtal      (dut_xtal),
        .dut_wr_n      (dut_wr_n),
        .dut_oe_n      (dut_oe_n),
        .dut_data_out  (dut_data_out),
        .dut_data_oe   (dut_data_oe),
        .dut_data_in   (dut_data_in),
        .dut_rdy       (dut_rdy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pins in cycle 1 (first cycle after accept), strobe counts over the op,
    // latency in cycles from the accept cycle to the rsp_valid cycle.
    typedef struct {
        logic [2:0] op;
        logic       bs1;
        logic       bs2;
        logic [7:0] data;
        logic [7:0] din;
        logic [1:0] xa;
        logic       bs1p;
        logic       doe;
        int         first;
        int         n_xtal;
        int         n_wr;
        int         n_oe;
        int         n_bs1;
        int         lat;
        logic [7:0] rsp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];
    vec_t v;

    int lat, first, nx, nw, no, nb, rel, rise, seen, nrsp;
    logic saw_low;

    task automatic issue(input logic [2:0] op, input logic b1, input logic b2, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_bs1   = b1;
        cmd_bs2   = b2;
        cmd_data  = d;
    endtask

    initial begin
        //           op    bs1   bs2   data   din    xa     bs1p  doe  1st xt wr oe b1  lat rsp
        vecs[0] = '{3'd0, 1'b0, 1'b0, 8'h10, 8'h00, 2'b10, 1'b0, 1'b1, 3, 4, 0, 0, 0,  9, 8'h00};
        vecs[1] = '{3'd1, 1'b1, 1'b0, 8'h3C, 8'h00, 2'b00, 1'b1, 1'b1, 3, 4, 0, 0, 8,  9, 8'h00};
        vecs[2] = '{3'd2, 1'b0, 1'b0, 8'hC3, 8'h00, 2'b01, 1'b0, 1'b1, 3, 4, 0, 0, 0,  9, 8'h00};
        vecs[3] = '{3'd4, 1'b1, 1'b0, 8'h00, 8'hA5, 2'b01, 1'b1, 1'b0, 3, 0, 0, 3, 7,  8, 8'hA5};
        vecs[4] = '{3'd4, 1'b0, 1'b1, 8'h00, 8'h5A, 2'b11, 1'b0, 1'b0, 3, 0, 0, 3, 0,  8, 8'h5A};
        vecs[5] = '{3'd5, 1'b0, 1'b0, 8'h00, 8'h00, 2'b11, 1'b0, 1'b0, 3, 0, 0, 0, 4,  9, 8'h5A};
        vecs[6] = '{3'd3, 1'b1, 1'b1, 8'h00, 8'h00, 2'b11, 1'b1, 1'b0, 3, 0, 4, 0, 16, 17, 8'h5A};
        vecs[7] = '{3'd6, 1'b0, 1'b0, 8'h00, 8'h00, 2'b11, 1'b0, 1'b0, 0, 0, 0, 0, 0,  1, 8'h5A};
        vecs[8] = '{3'd7, 1'b1, 1'b1, 8'h00, 8'h00, 2'b11, 1'b0, 1'b0, 0, 0, 0, 0, 0,  1, 8'h5A};
        vecs[9] = '{3'd0, 1'b1, 1'b0, 8'hFF, 8'h00, 2'b10, 1'b0, 1'b1, 3, 4, 0, 0, 0,  9, 8'h5A};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_xa", {dut_xa1_bs2, dut_xa0}, 2'b11);
        chk("rst_bs1", dut_pagel_bs1, 0);
        chk("rst_xtal", dut_xtal, 0);
        chk("rst_wr_n", dut_wr_n, 1);
        chk("rst_oe_n", dut_oe_n, 1);
        chk("rst_data_out", dut_data_out, 8'h00);
        chk("rst_data_oe", dut_data_oe, 0);
        rst_n = 1'b1;

        // Table-driven single ops
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            @(negedge clk);
            chk("pre_ready", cmd_ready, 1);
            dut_data_in = v.din;
            issue(v.op, v.bs1, v.bs2, v.data);
            lat = 0; first = 0; nx = 0; nw = 0; no = 0; nb = 0;
            for (int c = 1; c <= 60; c++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                if (c == 1) begin
                    chk("setup_xa", {dut_xa1_bs2, dut_xa0}, v.xa);
                    chk("setup_bs1", dut_pagel_bs1, v.bs1p);
                    chk("setup_data_oe", dut_data_oe, v.doe);
                    if (v.doe) chk("setup_data_out", dut_data_out, v.data);
                end
                if (dut_xtal) nx++;
                if (!dut_wr_n) nw++;
                if (!dut_oe_n) no++;
                if (dut_pagel_bs1) nb++;
                if (first == 0 && (dut_xtal || !dut_wr_n || !dut_oe_n ||
                                   (v.op == 3'd5 && dut_pagel_bs1)))
                    first = c;
                if (rsp_valid) begin
                    lat = c;
                    chk("rsp_data", rsp_data, v.rsp);
                    chk("rsp_err", rsp_err, 0);
                    chk("done_ready", cmd_ready, 0);
                    break;
                end
            end
            chk("latency", lat, v.lat);
            chk("first_strobe", first, v.first);
            chk("xtal_cycles", nx, v.n_xtal);
            chk("wr_cycles", nw, v.n_wr);
            chk("oe_cycles", no, v.n_oe);
            chk("bs1_cycles", nb, v.n_bs1);
            @(negedge clk);
            chk("post_ready", cmd_ready, 1);
            chk("post_xa", {dut_xa1_bs2, dut_xa0}, 2'b11);
            chk("post_data_oe", dut_data_oe, 0);
        end

        // WRITE with BSY asserted 3 cycles after WR release, held 20 cycles
        @(negedge clk);
        issue(3'd3, 1'b0, 1'b0, 8'h00);
        saw_low = 1'b0; rel = 0; rise = 0; seen = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (!dut_wr_n) saw_low = 1'b1;
            else if (saw_low && rel == 0) rel = c;
            if (rel != 0 && c == rel + 3) dut_rdy = 1'b0;
            if (rel != 0 && c == rel + 23) begin
                chk("wr_busy_hold", cmd_ready, 0);
                dut_rdy = 1'b1;
                rise = c;
            end
            if (rsp_valid) begin
                seen = c;
                chk("wr_rsp_err", rsp_err, 0);
                break;
            end
        end
        chk("wr_release_cycle", rel, 7);
        // two synchroniser flops, one cycle in WAIT_RDY, two HOLD cycles
        chk("wr_rdy_to_rsp", seen - rise, 5);

        // Back-to-back cmd_valid while busy is dropped
        @(negedge clk);
        issue(3'd2, 1'b0, 1'b0, 8'h77);
        @(negedge clk);
        issue(3'd0, 1'b0, 1'b0, 8'h99);
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        nrsp = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        chk("b2b_rsp_count", nrsp, 1);
        chk("b2b_data_out", dut_data_out, 8'h77);
        chk("b2b_ready", cmd_ready, 1);

        // RDY stuck low after the write
        @(negedge clk);
        dut_rdy = 1'b0;
        repeat (3) @(negedge clk);
        issue(3'd3, 1'b0, 1'b0, 8'h00);
`ifdef HVPP_RDY_TIMEOUT_EN
        seen = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rsp_valid) begin
                seen = c;
                chk("to_rsp_err", rsp_err, 1);
                break;
            end
        end
        // 2 SETUP + 4 WR + 1 WAIT_BSY + 100 WAIT_RDY + 2 HOLD + DONE
        chk("to_latency", seen, 110);
`else
        nrsp = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rsp_valid) nrsp++;
        end
        chk("stuck_busy", cmd_ready, 0);
        chk("stuck_no_rsp", nrsp, 0);
        rst_n = 1'b0;
        #1;
        chk("stuck_rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
`endif
        dut_rdy = 1'b1;
        repeat (4) @(negedge clk);

        // Reset during the XTAL pulse
        issue(3'd0, 1'b0, 1'b0, 8'h10);
        seen = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (dut_xtal) begin
                seen = c;
                break;
            end
        end
        chk("rst_mid_xtal_seen", seen, 3);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_xtal", dut_xtal, 0);
        chk("rst_mid_xa", {dut_xa1_bs2, dut_xa0}, 2'b11);
        chk("rst_mid_ready", cmd_ready, 1);
        chk("rst_mid_data_oe", dut_data_oe, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        chk("rst_mid_no_rsp", nrsp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
